vce_palette_loader: RTL and testbench

- CPU-side bus initiator for the HuC6260 VCE register port.
- On a start request it programs the control register, sets the colour-table address and streams N 9-bit palette entries from a synchronous source memory into colour RAM.
- Optionally reads every entry back through the same port and flags mismatches.
- Replaces CPU-driven palette uploads during boot and scene changes.

---
 rtl/vce_palette_loader.sv | 219 +++++++++++++++++++++
 tb/tb_vce_palette_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vce_palette_loader.sv
// Bus initiator that uploads palette entries into the HuC6260 VCE colour RAM
// through its register port, with an optional readback-and-compare pass.
module vce_palette_loader #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [8:0] base_addr,
  input  logic [9:0] count,
  input  logic       verify_en,
  output logic [8:0] src_addr,
  input  logic [8:0] src_data,
  output logic [2:0] A,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] D_in,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] err_addr
);

  localparam int BUS_LEN = SETUP_CYC + PULSE_CYC + HOLD_CYC;
  localparam logic [7:0] P_STRB = 8'(SETUP_CYC);
  localparam logic [7:0] P_HOLD = 8'(SETUP_CYC + PULSE_CYC);
  localparam logic [7:0] P_LAST = 8'(BUS_LEN - 1);

  typedef enum logic [1:0] {IDLE, BUS, FETCH, VERIFY_DONE} state_t;
  typedef enum logic [3:0] {
    W_CR, W_CTAL, W_CTAH, W_LO, W_HI, R_CTAL, R_CTAH, R_LO, R_HI
  } step_t;

  state_t     state;
  step_t      step;
  logic [7:0] pcnt;
  logic       fcnt;
  logic [1:0] mode_q;
  logic [8:0] base_q;
  logic [9:0] total;
  logic       verify_q;
  logic [9:0] index;
  logic [8:0] cta;
  logic [8:0] entry;

  logic [2:0] step_a;
  logic [7:0] step_d;
  logic       step_write;
  logic       strobe_on;
  logic       last_entry;
  logic       capture;
  logic [8:0] cur_entry;

  // The first bus clock of W_LO/R_LO coincides with the end of FETCH, so the
  // freshly arrived source word is used directly while it is being captured.
  always_comb begin
    capture    = (step == W_LO || step == R_LO) && (pcnt == 8'd0);
    cur_entry  = capture ? src_data : entry;
    strobe_on  = (pcnt >= P_STRB) && (pcnt < P_HOLD);
    last_entry = (index == total - 10'd1);
    step_a     = 3'd0;
    step_d     = 8'h00;
    step_write = 1'b1;
    case (step)
      W_CR:           step_d = {6'b0, mode_q};
      W_CTAL, R_CTAL: begin step_a = 3'd2; step_d = base_q[7:0]; end
      W_CTAH, R_CTAH: begin step_a = 3'd3; step_d = {7'b0, base_q[8]}; end
      W_LO:           begin step_a = 3'd4; step_d = cur_entry[7:0]; end
      W_HI:           begin step_a = 3'd5; step_d = {7'b0, cur_entry[8]}; end
      R_LO:           begin step_a = 3'd4; step_write = 1'b0; end
      R_HI:           begin step_a = 3'd5; step_write = 1'b0; end
      default:        step_a = 3'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      step     <= W_CR;
      pcnt     <= 8'd0;
      fcnt     <= 1'b0;
      mode_q   <= 2'd0;
      base_q   <= 9'd0;
      total    <= 10'd0;
      verify_q <= 1'b0;
      index    <= 10'd0;
      cta      <= 9'd0;
      entry    <= 9'd0;
      src_addr <= 9'd0;
      A        <= 3'd0;
      D_out    <= 8'h00;
      D_oe     <= 1'b0;
      CS_n     <= 1'b1;
      WR_n     <= 1'b1;
      RD_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_addr <= 9'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            mode_q   <= mode;
            base_q   <= base_addr;
            total    <= (count == 10'd0) ? 10'd512 : count;
            verify_q <= verify_en;
            error    <= 1'b0;
            step     <= W_CR;
            pcnt     <= 8'd0;
            state    <= BUS;
          end
        end

        BUS: begin
          busy <= 1'b1;
          CS_n <= 1'b0;
          A    <= step_a;
          D_oe <= step_write;
          WR_n <= !(step_write && strobe_on);
          RD_n <= !(!step_write && strobe_on);
          if (step_write) D_out <= step_d;
          if (capture) entry <= src_data;
          // Readback data is taken at the end of the last strobe-low clock.
          if (!step_write && pcnt == P_HOLD) begin
            if ((step == R_LO && D_in != entry[7:0]) ||
                (step == R_HI && D_in[0] != entry[8])) begin
              if (!error) err_addr <= cta;
              error <= 1'b1;
            end
          end
          if (pcnt == P_LAST) begin
            pcnt <= 8'd0;
            case (step)
              W_CR:   step <= W_CTAL;
              W_CTAL: step <= W_CTAH;
              W_CTAH: begin
                step  <= W_LO;
                index <= 10'd0;
                cta   <= base_q;
                state <= FETCH;
              end
              W_LO:   step <= W_HI;
              W_HI: begin
                cta <= cta + 9'd1;
                if (!last_entry) begin
                  index <= index + 10'd1;
                  step  <= W_LO;
                  state <= FETCH;
                end else if (verify_q) begin
                  step <= R_CTAL;
                end else begin
                  state <= VERIFY_DONE;
                end
              end
              R_CTAL: step <= R_CTAH;
              R_CTAH: begin
                step  <= R_LO;
                index <= 10'd0;
                cta   <= base_q;
                state <= FETCH;
              end
              R_LO:   step <= R_HI;
              R_HI: begin
                cta <= cta + 9'd1;
                if (!last_entry) begin
                  index <= index + 10'd1;
                  step  <= R_LO;
                  state <= FETCH;
                end else begin
                  state <= VERIFY_DONE;
                end
              end
              default: state <= VERIFY_DONE;
            endcase
          end else begin
            pcnt <= pcnt + 8'd1;
          end
        end

        FETCH: begin
          busy <= 1'b1;
          CS_n <= 1'b1;
          D_oe <= 1'b0;
          WR_n <= 1'b1;
          RD_n <= 1'b1;
          if (!fcnt) begin
            src_addr <= index[8:0];
            fcnt     <= 1'b1;
          end else begin
            fcnt  <= 1'b0;
            pcnt  <= 8'd0;
            state <= BUS;
          end
        end

        VERIFY_DONE: begin
          CS_n  <= 1'b1;
          D_oe  <= 1'b0;
          WR_n  <= 1'b1;
          RD_n  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vce_palette_loader.sv
// Directed bench for vce_palette_loader: a behavioural VCE register port and
// source memory, a table of load vectors and hand sequences for corner cases.
module tb_vce_palette_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [8:0] base_addr;
  logic [9:0] count;
  logic       verify_en;
  logic [8:0] src_addr;
  logic [8:0] src_data;
  logic [2:0] A;
  logic [7:0] D_out;
  logic       D_oe;
  logic [7:0] D_in;
  logic       CS_n, WR_n, RD_n;
  logic       busy, done, error;
  logic [8:0] err_addr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0, lb, wb;

  logic [8:0] src_mem [512];
  logic [8:0] vram [512] = '{default: 9'h000};
  logic [8:0] mcta = 9'd0;
  logic [7:0] mlo = 8'h00;
  logic [7:0] mcr = 8'h00;
  logic [9:0] corrupt = 10'h3FF;
  logic       prev_wr = 1'b1;
  logic       prev_rd = 1'b1;
  int         wr_run = 0;
  int         wr_widths[$];
  logic [2:0] log_a[$];
  logic [7:0] log_d[$];
  logic [8:0] log_s[$];
  logic [8:0] log_c[$];

  vce_palette_loader dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .count(count), .verify_en(verify_en),
    .src_addr(src_addr), .src_data(src_data), .A(A), .D_out(D_out),
    .D_oe(D_oe), .D_in(D_in), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) src_data <= src_mem[src_addr];

  // VCE model: writes act on the strobe falling edge, reads of A=5 advance CTA
  // when the strobe rises; one address can be made to read back bit 8 flipped.
  always @(posedge clock) begin
    if (!CS_n && !WR_n && prev_wr) begin
      log_a.push_back(A);
      log_d.push_back(D_out);
      log_s.push_back(src_addr);
      log_c.push_back(mcta);
      case (A)
        3'd0: mcr <= D_out;
        3'd2: mcta[7:0] <= D_out;
        3'd3: mcta[8] <= D_out[0];
        3'd4: mlo <= D_out;
        3'd5: begin
          vram[mcta] <= {D_out[0], mlo};
          mcta <= mcta + 9'd1;
        end
        default: ;
      endcase
    end
    if (!CS_n && !prev_rd && RD_n && A == 3'd5) mcta <= mcta + 9'd1;
    if (!WR_n) wr_run <= wr_run + 1;
    else if (!prev_wr) begin
      wr_widths.push_back(wr_run);
      wr_run <= 0;
    end
    prev_wr <= WR_n;
    prev_rd <= RD_n;
  end

  always_comb begin
    D_in = 8'h00;
    if (A == 3'd4) D_in = vram[mcta][7:0];
    else if (A == 3'd5) D_in = {7'b0, vram[mcta][8] ^ ({1'b0, mcta} == corrupt)};
  end

  typedef struct {
    logic [1:0] mode;
    logic [8:0] base;
    logic [9:0] count;
    logic       verify;
    logic [9:0] corrupt;
    int         lat;
    logic       err;
    logic [8:0] err_addr;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] m, input logic [8:0] b,
                                input logic [9:0] c, input logic v);
    @(negedge clock);
    mode = m; base_addr = b; count = c; verify_en = v; start = 1'b1;
    lb = log_a.size();
    wb = wr_widths.size();
    @(negedge clock);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int limit, output int lat, output int busy_n);
    lat = -1;
    busy_n = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  task automatic check_ram(input string name, input logic [8:0] b, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      logic [8:0] a = b + 9'(i);
      if (vram[a] !== src_mem[i]) bad++;
    end
    check_output(name, bad, 0);
  endtask

  task automatic check_log(input string name, input int n, input logic v);
    int k = 0;
    int bad = 0;
    for (int j = lb; j < log_a.size(); j++) begin
      if (log_a[j] == 3'd4) begin
        if (log_s[j] != 9'(k)) bad++;
        k++;
      end
    end
    check_output({name, "_writes"}, log_a.size() - lb, 3 + 2 * n + (v ? 2 : 0));
    check_output({name, "_src_order"}, bad, 0);
  endtask

  initial begin
    vec_t vecs[5];
    int lat, bn;
    logic [2:0] exp_a[5];
    logic [7:0] exp_d[5];
    int found;

    vecs[0] = '{2'd1, 9'h020, 10'd2, 1'b0, 10'h3FF, 33, 1'b0, 9'h000};
    vecs[1] = '{2'd3, 9'h1FE, 10'd4, 1'b0, 10'h3FF, 53, 1'b0, 9'h000};
    vecs[2] = '{2'd0, 9'h005, 10'd3, 1'b1, 10'h006, 81, 1'b1, 9'h006};
    vecs[3] = '{2'd2, 9'h100, 10'd3, 1'b1, 10'h3FF, 81, 1'b0, 9'h000};
    vecs[4] = '{2'd0, 9'h1FF, 10'd2, 1'b1, 10'h1FF, 61, 1'b1, 9'h1FF};
    exp_a = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
    exp_d = '{8'h02, 8'h10, 8'h00, 8'hA5, 8'h01};

    for (int i = 0; i < 512; i++) src_mem[i] = 9'(i * 77 + 'h1A5);
    reset = 1'b1; start = 1'b0; mode = 2'd0; base_addr = 9'd0; count = 10'd0; verify_en = 1'b0;
    repeat (3) @(negedge clock);
    check_output("reset_ctrl", {CS_n, WR_n, RD_n, D_oe, busy, done, error}, 7'b1110000);
    check_output("reset_bus", {A, D_out, src_addr, err_addr}, 0);
    reset = 1'b0;

    // Single entry, bus sequence and strobe width
    apply_stimulus(2'd2, 9'h010, 10'd1, 1'b0);
    wait_done(200, lat, bn);
    check_output("t1_latency", lat, 23);
    check_output("t1_writes", log_a.size() - lb, 5);
    for (int j = 0; j < 5 && lb + j < log_a.size(); j++) begin
      check_output($sformatf("t1_A%0d", j), log_a[lb + j], exp_a[j]);
      check_output($sformatf("t1_D%0d", j), log_d[lb + j], exp_d[j]);
    end
    check_output("t1_src_addr", log_s[lb + 3], 0);
    check_output("t1_strobes", wr_widths.size() - wb, 5);
    for (int j = wb; j < wr_widths.size(); j++) check_output("t1_wr_width", wr_widths[j], 2);

    for (int v = 0; v < 5; v++) begin
      corrupt = vecs[v].corrupt;
      apply_stimulus(vecs[v].mode, vecs[v].base, vecs[v].count, vecs[v].verify);
      wait_done(500, lat, bn);
      check_output($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check_output($sformatf("v%0d_busy", v), bn, vecs[v].lat - 1);
      check_output($sformatf("v%0d_error", v), error, vecs[v].err);
      if (vecs[v].err) check_output($sformatf("v%0d_err_addr", v), err_addr, vecs[v].err_addr);
      check_output($sformatf("v%0d_cr", v), mcr, {6'b0, vecs[v].mode});
      check_ram($sformatf("v%0d_ram", v), vecs[v].base, int'(vecs[v].count));
      check_log($sformatf("v%0d", v), int'(vecs[v].count), vecs[v].verify);
    end
    corrupt = 10'h3FF;

    // Start and parameter changes while busy are ignored
    apply_stimulus(2'd1, 9'h040, 10'd3, 1'b0);
    repeat (5) @(negedge clock);
    base_addr = 9'h1C0; count = 10'd7; verify_en = 1'b1; mode = 2'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(500, lat, bn);
    check_output("mid_latency", lat, 43);
    check_output("mid_cr", mcr, 8'h01);
    check_ram("mid_ram", 9'h040, 3);
    check_log("mid", 3, 1'b0);

    // Reset during the W_LO strobe of entry 5
    apply_stimulus(2'd0, 9'h000, 10'd8, 1'b0);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clock);
      if (log_a.size() > lb && log_a[$] == 3'd4 && log_s[$] == 9'd5) found = 1;
    end
    check_output("abort_reached", found, 1);
    check_output("abort_in_pulse", WR_n, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_output("abort_bus", {CS_n, WR_n, D_oe, busy, done}, 5'b11000);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done || busy) found++;
    end
    check_output("abort_quiet", found, 0);
    apply_stimulus(2'd1, 9'h080, 10'd2, 1'b1);
    wait_done(500, lat, bn);
    check_output("after_abort_latency", lat, 61);
    check_output("after_abort_error", error, 1'b0);
    check_ram("after_abort_ram", 9'h080, 2);

    // count = 0 loads all 512 entries and wraps the colour-table address
    apply_stimulus(2'd2, 9'h0A0, 10'd0, 1'b0);
    wait_done(6000, lat, bn);
    check_output("full_latency", lat, 5133);
    check_ram("full_ram", 9'h0A0, 512);
    check_output("full_writes", log_a.size() - lb, 1027);
    check_output("full_last_hi_addr", log_c[$], 9'h09F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
